// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request and response bundle between the core's MEM stage and the data memory
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_stall;
  modport master(
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_stall
  );
  modport slave(
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM with byte-lane stores, programmable wait states and MEM-stage stall
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input logic           clk,
  input logic           rst,
  data_mem_responder_if.slave s
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] be_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle, cur_wr, cur_err, enter_resp;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0] cur_be;
  logic [AW-1:0] idx;
  assign idle = state == IDLE;
  // With zero latency the response edge is the accept edge, so use the live request in IDLE
  always_comb begin
    cur_wr = idle ? s.req_write : wr_q;
    cur_addr = idle ? s.req_addr : addr_q;
    cur_wdata = idle ? s.req_wdata : wdata_q;
    cur_be = idle ? s.req_be : be_q;
    cur_err = (|cur_addr[1:0]) | (|cur_addr[31:AW+2]);
    idx = cur_addr[AW+1:2];
  end
  always_comb begin
    nxt = state;
    nxt = state == RESP ? IDLE
        : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
        : s.req_valid ? (LATENCY == 0 ? RESP : WAIT) : IDLE;
    enter_resp = nxt == RESP && state != RESP;
  end
  assign s.req_ready = idle;
  assign s.resp_valid = state == RESP;
  assign s.mem_stall = (idle & s.req_valid) | (state == WAIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      s.resp_rdata <= 32'd0;
      s.resp_err <= 1'b0;
    end else begin
      state <= nxt;
      if (idle && s.req_valid) begin
        wr_q <= s.req_write;
        addr_q <= s.req_addr;
        wdata_q <= s.req_wdata;
        be_q <= s.req_be;
        cnt <= 4'(LATENCY == 0 ? 0 : LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        s.resp_rdata <= (cur_wr | cur_err) ? 32'd0 : mem[idx];
        s.resp_err <= cur_err;
      end else if (state == RESP) begin
        s.resp_err <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_wr && !cur_err)
      for (int i = 0; i < 4; i++)
        if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector table plus reset-abort and zero-latency back-to-back sequences
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_mem_responder_if m2();
  data_mem_responder_if m0();
  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut2(.clk(clk), .rst(rst), .s(m2.slave));
  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) dut0(.clk(clk), .rst(rst), .s(m0.slave));
  int total = 0;
  int bad = 0;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic access(input string n, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] rdata, input logic err);
    int k, stalls, readies;
    bit got;
    k = -1; stalls = 0; readies = 0; got = 0;
    @(negedge clk);
    m2.req_valid = 1'b1; m2.req_write = wr; m2.req_addr = addr; m2.req_wdata = wdata; m2.req_be = be;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m2.resp_valid) begin
        got = 1; k = i;
        break;
      end
      if (m2.mem_stall) stalls++;
      if (m2.req_ready) readies++;
      @(negedge clk);
    end
    if (!got) begin
      chk({n, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({n, " latency"}, k, 32'd3);
      chk({n, " rdata"}, m2.resp_rdata, rdata);
      chk({n, " err"}, {31'd0, m2.resp_err}, {31'd0, err});
      chk({n, " stall cycles"}, stalls, 32'd3);
      chk({n, " ready cycles"}, readies, 32'd1);
      chk({n, " stall in resp"}, {31'd0, m2.mem_stall}, 32'd0);
    end
    m2.req_valid = 1'b0;
  endtask
  initial begin
    int seen;
    m2.req_valid = 0; m2.req_write = 0; m2.req_addr = 0; m2.req_wdata = 0; m2.req_be = 0;
    m0.req_valid = 0; m0.req_write = 0; m0.req_addr = 0; m0.req_wdata = 0; m0.req_be = 0;
    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,  32'h0000AA00, 4'h2, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADAAEF, 1'b0};
    tbl[4]  = '{1'b0, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1};
    tbl[5]  = '{1'b1, 32'h12,  32'h11111111, 4'hF, 32'h0,        1'b1};
    tbl[6]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADAAEF, 1'b0};
    tbl[7]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 32'h200, 32'h99999999, 4'hF, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 32'h0,   32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b1, 32'h1FC, 32'h55AA55AA, 4'hF, 32'h0,        1'b0};
    tbl[11] = '{1'b1, 32'h1FC, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 32'h1FC, 32'h0,        4'hF, 32'h55AA55AA, 1'b0};
    tbl[13] = '{1'b1, 32'h210, 32'h77777777, 4'hF, 32'h0,        1'b1};
    tbl[14] = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADAAEF, 1'b0};
    tbl[15] = '{1'b1, 32'h20,  32'h0,        4'hF, 32'h0,        1'b0};
    repeat (2) @(negedge clk);
    #1;
    chk("rst resp_valid", {31'd0, m2.resp_valid}, 32'd0);
    chk("rst rdata", m2.resp_rdata, 32'd0);
    chk("rst err", {31'd0, m2.resp_err}, 32'd0);
    chk("rst ready", {31'd0, m2.req_ready}, 32'd1);
    chk("rst stall", {31'd0, m2.mem_stall}, 32'd0);
    rst = 1'b0;
    for (int v = 0; v < 16; v++)
      access($sformatf("vec%0d", v), tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].be, tbl[v].rdata, tbl[v].err);
    @(negedge clk);
    m2.req_valid = 1'b1; m2.req_write = 1'b1; m2.req_addr = 32'h20; m2.req_wdata = 32'h12345678; m2.req_be = 4'hF;
    @(negedge clk);
    #1;
    chk("abort in wait stall", {31'd0, m2.mem_stall}, 32'd1);
    rst = 1'b1;
    m2.req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("abort resp_valid", {31'd0, m2.resp_valid}, 32'd0);
    chk("abort ready", {31'd0, m2.req_ready}, 32'd1);
    chk("abort stall", {31'd0, m2.mem_stall}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (m2.resp_valid) seen++;
    end
    chk("abort no resp", seen, 32'd0);
    access("abort readback", 1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    m0.req_valid = 1'b1; m0.req_write = 1'b1; m0.req_addr = 32'h0; m0.req_wdata = 32'hA5A5A5A5; m0.req_be = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("lat0 c%0d ready", c), {31'd0, m0.req_ready}, {31'd0, c % 2 == 0});
      chk($sformatf("lat0 c%0d stall", c), {31'd0, m0.mem_stall}, {31'd0, c % 2 == 0});
      chk($sformatf("lat0 c%0d valid", c), {31'd0, m0.resp_valid}, {31'd0, c % 2 == 1});
      if (c % 2 == 1) chk($sformatf("lat0 c%0d rdata", c), m0.resp_rdata, c == 1 ? 32'h0 : 32'hA5A5A5A5);
      if (c == 1) m0.req_write = 1'b0;
      @(negedge clk);
    end
    m0.req_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
